// File: rtl/demux1_to_8_reg.sv
// 1-to-8 registered demultiplexer with per-slot valid/ack handshake.
// A write lands in the slot chosen by {s2,s1,s0}; each slot is drained independently via out_ack.
module demux1_to_8_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        s2,
    input  logic        s1,
    input  logic        s0,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic [31:0] d,
    output logic [31:0] e,
    output logic [31:0] f,
    output logic [31:0] g,
    output logic [31:0] h,
    output logic [7:0]  out_valid,
    input  logic [7:0]  out_ack,
    output logic [3:0]  count
);

    logic [2:0]  sel;
    logic        accept;
    logic        fill_empty;
    logic [7:0]  wr_mask;
    logic [7:0]  eff_ack;
    logic [3:0]  ack_cnt;
    logic [7:0]  valid_next;
    logic [3:0]  count_next;
    logic [31:0] slot [8];

    always_comb begin
        sel        = {s2, s1, s0};
        in_ready   = !out_valid[sel] || out_ack[sel];
        accept     = in_valid && in_ready && !rst;
        fill_empty = accept && !out_valid[sel];
        wr_mask    = accept ? (8'b1 << sel) : 8'b0;
        // An ack on the slot being refilled is absorbed by the write, so it never drops count.
        eff_ack    = out_ack & out_valid & ~wr_mask;
        ack_cnt    = 4'd0;
        for (int k = 0; k < 8; k++) begin
            ack_cnt = ack_cnt + 4'(eff_ack[k]);
        end
        valid_next = (out_valid & ~eff_ack) | wr_mask;
        count_next = count + 4'(fill_empty) - ack_cnt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 8'h00;
            count     <= 4'd0;
            // NOTE: the slot array is reset because cleared data is architecturally visible on a..h.
            for (int k = 0; k < 8; k++) begin
                slot[k] <= 32'h0;
            end
        end else begin
            out_valid <= valid_next;
            count     <= count_next;
            if (accept) begin
                slot[sel] <= in_data;
            end
        end
    end

    assign a = slot[0];
    assign b = slot[1];
    assign c = slot[2];
    assign d = slot[3];
    assign e = slot[4];
    assign f = slot[5];
    assign g = slot[6];
    assign h = slot[7];

    count_consistent : assert property (@(posedge clk) disable iff (rst)
        (count <= 4'd8) && (count == 4'($countones(out_valid))));

endmodule

// File: tb/tb_demux1_to_8_reg.sv
// Directed self-checking bench for demux1_to_8_reg with hand-computed expectations.
module tb_demux1_to_8_reg;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        s2, s1, s0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;

    demux1_to_8_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .s2        (s2),
        .s1        (s1),
        .s0        (s0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [2:0] sel, input logic [31:0] data);
        {s2, s1, s0} = sel;
        in_data      = data;
        in_valid     = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_data = 32'h0; {s2, s1, s0} = 3'd0; in_valid = 1'b0; out_ack = 8'h00;

        // Reset state before any clock edge
        #2;
        check("rst_a", a, 32'h0);
        check("rst_h", h, 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);

        // A write presented during reset must not land
        drive_write(3'd0, 32'h5555_5555);
        tick();
        check("rst_no_write_a", a, 32'h0);
        check("rst_no_write_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;

        // Fill all 8 slots
        for (int k = 0; k < 8; k++) begin
            drive_write(3'(k), 32'h1000_0000 + k);
            #1 check("fill_ready", 32'(in_ready), 32'h1);
            tick();
        end
        in_valid = 1'b0;
        check("fill_valid", 32'(out_valid), 32'hFF);
        check("fill_count", 32'(count), 32'h8);
        check("fill_a", a, 32'h1000_0000);
        check("fill_d", d, 32'h1000_0003);
        check("fill_h", h, 32'h1000_0007);

        // Backpressure on full slot 3
        drive_write(3'd3, 32'hDEAD_BEEF);
        #1 check("bp_ready_low", 32'(in_ready), 32'h0);
        tick();
        check("bp_d_held", d, 32'h1000_0003);
        check("bp_count", 32'(count), 32'h8);
        out_ack = 8'h08;
        #1 check("bp_ready_ack", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; out_ack = 8'h00;
        check("refill_d", d, 32'hDEAD_BEEF);
        check("refill_valid", 32'(out_valid), 32'hFF);
        check("refill_count", 32'(count), 32'h8);

        // Drain everything except slots 0, 5, 7
        out_ack = 8'h5E;
        tick();
        out_ack = 8'h00;
        check("drain_valid", 32'(out_valid), 32'hA1);
        check("drain_count", 32'(count), 32'h3);
        check("drain_d_kept", d, 32'hDEAD_BEEF);

        // Multi-ack of the remaining slots
        out_ack = 8'hA1;
        tick();
        out_ack = 8'h00;
        check("mack_valid", 32'(out_valid), 32'h00);
        check("mack_count", 32'(count), 32'h0);
        check("mack_a", a, 32'h1000_0000);
        check("mack_f", f, 32'h1000_0005);
        check("mack_h", h, 32'h1000_0007);

        // Spurious ack on empty slots
        out_ack = 8'hFF;
        tick();
        out_ack = 8'h00;
        check("spur_valid", 32'(out_valid), 32'h00);
        check("spur_count", 32'(count), 32'h0);
        check("spur_b", b, 32'h1000_0001);

        // Write to an empty slot while acking another one keeps count level
        drive_write(3'd2, 32'h3000_0002);
        tick();
        drive_write(3'd5, 32'h3000_0005);
        out_ack = 8'h04;
        tick();
        in_valid = 1'b0; out_ack = 8'h00;
        check("swap_valid", 32'(out_valid), 32'h20);
        check("swap_count", 32'(count), 32'h1);
        check("swap_f", f, 32'h3000_0005);
        check("swap_c_kept", c, 32'h3000_0002);

        // Build count=5 (slot 5 already valid, add 0..3)
        for (int k = 0; k < 4; k++) begin
            drive_write(3'(k), 32'h2000_0000 + k);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 32'h5);
        check("pre_rst_valid", 32'(out_valid), 32'h2F);

        // Async reset between edges
        #3 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'h0);
        check("arst_valid", 32'(out_valid), 32'h00);
        check("arst_a", a, 32'h0);
        check("arst_f", f, 32'h0);
        tick();
        rst = 1'b0;

        // First accept right after reset release
        drive_write(3'd2, 32'h0000_00AA);
        tick();
        in_valid = 1'b0;
        check("post_rst_c", c, 32'h0000_00AA);
        check("post_rst_count", 32'(count), 32'h1);
        check("post_rst_valid", 32'(out_valid), 32'h04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux1_to_8_reg.md
DEMUX1_TO_8_REG -- requirements
Module: demux1_to_8_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_data  input  32  write value to be routed.
REQ-005 s2  input  1  destination select MSB.
REQ-006 s1  input  1  destination select middle bit.
REQ-007 s0  input  1  destination select LSB; sel = {s2,s1,s0}.
REQ-008 in_valid  input  1  write request present this cycle.
REQ-009 in_ready  output  1  destination can accept this cycle (combinational).
REQ-010 a, b, c, d, e, f, g, h  output  32 each  holding registers for sel 0..7 respectively.
REQ-011 out_valid  output  8  bit k=1 means register k holds unconsumed data (bit 0 = a ... bit 7 = h).
REQ-012 out_ack  input  8  bit k=1 means the consumer takes register k this cycle.
REQ-013 count  output  4  number of set out_valid bits, 0..8.

Function
REQ-014 Select mapping SHALL be the exact inverse of the team's 8-to-1 mux: sel 0->a, 1->b, 2->c, 3->d, 4->e, 5->f, 6->g, 7->h.
REQ-015 in_ready SHALL be !out_valid[sel] | out_ack[sel], evaluated combinationally from current state and inputs.
REQ-016 A write is accepted when in_valid & in_ready at a rising edge.
REQ-017 On accept, register[sel] SHALL load in_data and out_valid[sel] SHALL be set at that edge (one-cycle latency to output).
REQ-018 in_valid with in_ready=0: no state change, and the request SHALL be held by the source (no drop, no partial write).
REQ-019 out_ack[k] with out_valid[k]=1 SHALL clear out_valid[k] at the edge unless slot k is written at the same edge.
REQ-020 out_ack[k] with out_valid[k]=0 SHALL be ignored.
REQ-021 Simultaneous ack and write to the same slot SHALL leave out_valid[k]=1 with the new data (refill, no bubble).
REQ-022 Any number of out_ack bits MAY be asserted in one cycle; each SHALL be handled independently.
REQ-023 Register contents SHALL NOT be cleared by ack; only a write or rst changes them.
REQ-024 Non-selected registers SHALL hold their value on every cycle.
REQ-025 count SHALL be registered and equal popcount(out_valid) after every edge; per edge it moves by (+1 if write to an empty slot) minus (number of effective acks); refill per REQ-021 leaves the count unchanged.
REQ-026 count SHALL never exceed 8 or wrap below 0; the handshake makes both impossible, and an assertion SHALL flag any violation.
REQ-027 Select inputs SHALL be sampled only when in_valid=1; with in_valid=0 they are don't-care.

Reset
REQ-028 While rst=1, regardless of clk: a..h=32'h0, out_valid=8'h00, count=0.
REQ-029 in_ready SHALL read 1 during reset, but no write SHALL be accepted while rst=1.
REQ-030 A rst assertion mid-operation SHALL discard all pending data; the first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-031 Fill all 8 slots: sel 0..7 with data 32'h1000_0000+k, no acks -> out_valid=8'hFF, count=8, h=32'h1000_0007.
REQ-032 Backpressure: slot 3 valid, write sel=3 data 32'hDEAD_BEEF with out_ack=0 -> in_ready=0 and d unchanged; assert out_ack[3] -> in_ready=1, d=32'hDEAD_BEEF next cycle, out_valid[3]=1, count unchanged.
REQ-033 Multi-ack: slots 0, 5, 7 valid, out_ack=8'hA1 -> out_valid=8'h00, count=0 next cycle, data in a, f, h retained.
REQ-034 Spurious ack: out_ack=8'hFF with out_valid=8'h00 -> no change, count=0.
REQ-035 Async reset: assert rst between clock edges with count=5 -> outputs zero immediately without a clock edge; deassert, write sel=2 data 32'h0000_00AA -> c=32'h0000_00AA, count=1.
